// File: rtl/ahb_simple_master.sv
// ahb_simple_master: AHB-Lite initiator turning a valid/ready command stream into pipelined single transfers
//   hclk, hreset_n                         : bus clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/
//   cmd_size/cmd_wdata                     : command stream in; accepted when cmd_valid & cmd_ready
//   rsp_valid/rsp_rdata/rsp_err            : one response pulse per accepted command, in acceptance order
//   hsel/haddr/htrans/hwrite/hsize/hwdata  : registered AHB-Lite master outputs (NONSEQ/IDLE only)
//   hrdata/hready/hresp                    : slave return path
//   busy                                   : address phase, data phase, cancel or response still in flight
//   timeout_err                            : sticky wait-state timeout; live only when AHB_SIMPLE_MASTER_TIMEOUT_EN
//                                            is defined, otherwise tied to 0
module ahb_simple_master #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              hsel,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp,
   output logic              busy,
   output logic              timeout_err
);
   // haddr/hwrite/hsize double as the A-stage fields; a_wdata waits here until the data phase
   logic              a_valid;
   logic [DATA_W-1:0] a_wdata;
   logic              d_valid;
   logic              d_write;
   logic              cancel_pending;
   logic              accept;
   logic              d_done;
   logic              err_first;
   logic              cancel_emit;
   always_comb begin
      cmd_ready   = hreset_n & hready & ~hresp & ~cancel_pending;
      accept      = cmd_valid & cmd_ready;
      d_done      = d_valid & hready;
      err_first   = d_valid & hresp & ~hready;
      // the cancelled command answers once the errored transfer has left the D-stage
      cancel_emit = cancel_pending & ~d_valid;
   end
   assign htrans = a_valid ? 2'b10 : 2'b00;
   assign hsel   = a_valid | d_valid;
   assign busy   = a_valid | d_valid | cancel_pending | rsp_valid;
   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         a_valid        <= 1'b0;
         a_wdata        <= '0;
         haddr          <= '0;
         hwrite         <= 1'b0;
         hsize          <= '0;
         hwdata         <= '0;
         d_valid        <= 1'b0;
         d_write        <= 1'b0;
         cancel_pending <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_err        <= 1'b0;
         rsp_rdata      <= '0;
      end else begin
         rsp_valid <= d_done | cancel_emit;
         rsp_err   <= (d_done & hresp) | cancel_emit;
         rsp_rdata <= (d_done & ~hresp & ~d_write) ? hrdata : '0;
         if (hready) begin
            d_valid <= a_valid;
            d_write <= hwrite;
            hwdata  <= a_wdata;
            a_valid <= accept;
            if (accept) begin
               hwrite  <= cmd_write;
               haddr   <= cmd_addr;
               hsize   <= cmd_size;
               a_wdata <= cmd_wdata;
            end
         end else if (err_first) begin
            // first ERROR cycle: drop to IDLE and remember the command stranded in the address phase
            a_valid        <= 1'b0;
            cancel_pending <= cancel_pending | a_valid;
         end
         if (cancel_emit)
            cancel_pending <= 1'b0;
      end
   end
`ifdef AHB_SIMPLE_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic [TW-1:0] to_cnt_n;
   always_comb
      to_cnt_n = hready ? '0 : (d_valid && to_cnt != TW'(TIMEOUT_CYCLES)) ? to_cnt + TW'(1) : to_cnt;
   always_ff @(posedge hclk) begin
      if (!hreset_n) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         to_cnt      <= to_cnt_n;
         timeout_err <= timeout_err | (to_cnt_n == TW'(TIMEOUT_CYCLES));
      end
   end
`else
   // feature disabled: the limit parameter only folds into a constant 0
   assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_ahb_simple_master.sv
// tb_ahb_simple_master: self-checking bench for ahb_simple_master (vector table, corner sequences, random traffic)
module tb_ahb_simple_master;
   logic       hclk = 1'b0;
   logic       hreset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [2:0] cmd_addr = '0;
   logic [2:0] cmd_size = '0;
   logic [7:0] cmd_wdata = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       hsel;
   logic [2:0] haddr;
   logic [1:0] htrans;
   logic       hwrite;
   logic [2:0] hsize;
   logic [7:0] hwdata;
   logic [7:0] hrdata = '0;
   logic       hready = 1'b1;
   logic       hresp = 1'b0;
   logic       busy;
   logic       timeout_err;

`ifdef AHB_SIMPLE_MASTER_TIMEOUT_EN
   localparam logic EXP_TO = 1'b1;
`else
   localparam logic EXP_TO = 1'b0;
`endif

   ahb_simple_master dut (
      .hclk(hclk), .hreset_n(hreset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 hclk = ~hclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_cmd(input logic v, input logic w, input logic [2:0] a, input logic [2:0] s, input logic [7:0] d);
      cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
   endtask

   typedef struct {
      logic       write;
      logic [2:0] addr;
      logic [2:0] size;
      logic [7:0] wdata;
      logic [7:0] slave_rdata;
      int         waits;
      logic       err;
      logic [7:0] exp_rdata;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t vecs[7];

   // one isolated transfer: checks address phase, data phase, response value and latency from acceptance
   task automatic run_vec(input vec_t v);
      int lat;
      bit seen;
      @(negedge hclk);
      hready = 1; hresp = 0;
      set_cmd(1, v.write, v.addr, v.size, v.wdata);
      #1 chk("vec_cmd_ready", cmd_ready, 1);
      @(negedge hclk);
      cmd_valid = 0; lat = 0;
      #1;
      chk("vec_htrans", htrans, 2'b10);
      chk("vec_haddr", haddr, v.addr);
      chk("vec_hwrite", hwrite, v.write);
      chk("vec_hsize", hsize, v.size);
      chk("vec_hsel", hsel, 1);
      for (int i = 0; i < v.waits; i++) begin
         @(negedge hclk); lat++;
         hready = 0;
         #1;
         chk("vec_wait_idle", htrans, 2'b00);
         chk("vec_wait_ready", cmd_ready, 0);
         if (v.write) chk("vec_wait_hwdata", hwdata, v.wdata);
      end
      @(negedge hclk); lat++;
      if (v.err) begin
         hready = 0; hresp = 1;
         #1 chk("vec_err1_ready", cmd_ready, 0);
         @(negedge hclk); lat++;
         hready = 1; hresp = 1;
         #1 chk("vec_err2_ready", cmd_ready, 0);
      end else begin
         hready = 1; hresp = 0; hrdata = v.slave_rdata;
         #1 if (v.write) chk("vec_hwdata", hwdata, v.wdata);
      end
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(negedge hclk); lat++;
         hready = 1; hresp = 0; hrdata = 8'h77;
         #1 if (rsp_valid) seen = 1;
      end
      chk("vec_latency", seen ? lat : -1, v.exp_lat);
      chk("vec_rsp_err", rsp_err, v.exp_err);
      chk("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
      @(negedge hclk);
      #1;
      chk("vec_rsp_single", rsp_valid, 0);
      chk("vec_idle_busy", busy, 0);
   endtask

   // random-phase reference: per-command records in acceptance order
   logic       cw[512];
   logic [2:0] ca[512];
   logic [2:0] cs[512];
   logic [7:0] cd[512];
   logic       res_ok[512];
   logic       res_err[512];
   logic [7:0] res_d[512];

   task automatic resolve(input int i, input logic e, input logic [7:0] d);
      res_ok[i] = 1; res_err[i] = e; res_d[i] = d;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 3'd3, 3'd0, 8'hA5, 8'h77, 0, 1'b0, 8'h00, 1'b0, 2};
      vecs[1] = '{1'b0, 3'd5, 3'd0, 8'h00, 8'h3C, 0, 1'b0, 8'h3C, 1'b0, 2};
      vecs[2] = '{1'b0, 3'd2, 3'd0, 8'h00, 8'h5A, 3, 1'b0, 8'h5A, 1'b0, 5};
      vecs[3] = '{1'b1, 3'd7, 3'd0, 8'h11, 8'h66, 0, 1'b1, 8'h00, 1'b1, 3};
      vecs[4] = '{1'b0, 3'd0, 3'd1, 8'h00, 8'hFF, 1, 1'b1, 8'h00, 1'b1, 4};
      vecs[5] = '{1'b1, 3'd1, 3'd2, 8'h80, 8'h44, 2, 1'b0, 8'h00, 1'b0, 4};
      vecs[6] = '{1'b0, 3'd4, 3'd0, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b0, 2};

      // reset state, with a command offered while reset is held
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      set_cmd(1, 1, 3'd6, 3'd1, 8'hEE);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_htrans", htrans, 0);
      chk("rst_hsel", hsel, 0);
      chk("rst_haddr", haddr, 0);
      chk("rst_hwrite", hwrite, 0);
      chk("rst_hsize", hsize, 0);
      chk("rst_hwdata", hwdata, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
      @(negedge hclk);
      hreset_n = 1; cmd_valid = 0;
      #1 chk("rst_no_accept", htrans, 0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // four back-to-back writes
      for (int i = 0; i < 8; i++) begin
         @(negedge hclk);
         hready = 1; hresp = 0;
         set_cmd(i < 4, 1, 3'(i + 2), 3'd0, 8'(8'h10 * i + 8'h05));
         #1;
         if (i < 4) chk("burst_ready", cmd_ready, 1);
         if (i >= 1 && i <= 4) begin
            chk("burst_htrans", htrans, 2'b10);
            chk("burst_haddr", haddr, i + 1);
         end
         if (i >= 2 && i <= 5) chk("burst_hwdata", hwdata, 8'h10 * (i - 2) + 8'h05);
         if (i >= 3 && i <= 6) chk("burst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h200);
         if (i == 7) chk("burst_rsp_end", rsp_valid, 0);
      end

      // ERROR on a write to 7 while a read of 1 sits in the address phase
      @(negedge hclk);
      set_cmd(1, 1, 3'd7, 3'd0, 8'h42);
      @(negedge hclk);
      set_cmd(1, 0, 3'd1, 3'd0, 8'h00);
      #1 chk("err_a7_htrans", {htrans, haddr}, {2'b10, 3'd7});
      @(negedge hclk);
      cmd_valid = 0; hready = 0; hresp = 1;
      #1;
      chk("err_c1_addr", {htrans, haddr}, {2'b10, 3'd1});
      chk("err_c1_ready", cmd_ready, 0);
      @(negedge hclk);
      hready = 1; hresp = 1;
      #1;
      chk("err_c2_idle", htrans, 2'b00);
      chk("err_c2_ready", cmd_ready, 0);
      chk("err_c2_busy", busy, 1);
      @(negedge hclk);
      hresp = 0;
      set_cmd(1, 0, 3'd6, 3'd0, 8'h00);
      #1;
      chk("err_rsp1", {rsp_valid, rsp_err, rsp_rdata}, 10'h300);
      chk("err_c3_ready", cmd_ready, 0);
      chk("err_c3_idle", htrans, 2'b00);
      @(negedge hclk);
      #1;
      chk("err_rsp2", {rsp_valid, rsp_err, rsp_rdata}, 10'h300);
      chk("err_c4_idle", htrans, 2'b00);
      chk("err_c4_ready", cmd_ready, 1);
      @(negedge hclk);
      cmd_valid = 0;
      #1;
      chk("err_after_rsp", rsp_valid, 0);
      chk("err_after_addr", {htrans, haddr}, {2'b10, 3'd6});
      @(negedge hclk);
      hrdata = 8'h99;
      @(negedge hclk);
      hrdata = 8'h00;
      #1 chk("err_after_read", {rsp_valid, rsp_err, rsp_rdata}, 10'h299);

      // hresp with hready high and no first ERROR cycle: the pipelined read is kept
      @(negedge hclk);
      set_cmd(1, 1, 3'd2, 3'd0, 8'h24);
      @(negedge hclk);
      set_cmd(1, 0, 3'd3, 3'd0, 8'h00);
      @(negedge hclk);
      cmd_valid = 0; hresp = 1;
      #1;
      chk("viol_ready", cmd_ready, 0);
      chk("viol_addr", {htrans, haddr}, {2'b10, 3'd3});
      @(negedge hclk);
      hresp = 0; hrdata = 8'h5E;
      #1;
      chk("viol_rsp1", {rsp_valid, rsp_err, rsp_rdata}, 10'h300);
      chk("viol_idle", htrans, 2'b00);
      @(negedge hclk);
      hrdata = 8'h00;
      #1 chk("viol_rsp2", {rsp_valid, rsp_err, rsp_rdata}, 10'h25E);

      // long wait state
      @(negedge hclk);
      set_cmd(1, 0, 3'd6, 3'd0, 8'h00);
      @(negedge hclk);
      cmd_valid = 0;
      for (int i = 0; i < 18; i++) begin
         @(negedge hclk);
         hready = 0;
      end
      #1;
      chk("to_flag", timeout_err, EXP_TO);
      chk("to_hold", {hsel, htrans, busy}, {1'b1, 2'b00, 1'b1});
      hready = 1; hrdata = 8'h21;
      @(negedge hclk);
      hrdata = 8'h00;
      #1;
      chk("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h221);
      chk("to_sticky", timeout_err, EXP_TO);

      // reset while a read is in the data phase and a write in the address phase
      @(negedge hclk);
      set_cmd(1, 0, 3'd4, 3'd0, 8'h00);
      @(negedge hclk);
      set_cmd(1, 1, 3'd5, 3'd3, 8'h6B);
      @(negedge hclk);
      cmd_valid = 0; hready = 0; hreset_n = 0;
      #1 chk("mid_rst_ready", cmd_ready, 0);
      @(negedge hclk);
      hreset_n = 1; hready = 1;
      #1;
      chk("mid_rst_bus", {hsel, htrans, haddr, hwrite, hsize, hwdata}, 0);
      chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      chk("mid_rst_flags", {busy, timeout_err}, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge hclk);
         #1 chk("mid_rst_no_rsp", {rsp_valid, busy}, 0);
      end

      // random traffic against a transaction-level model: slave waits, errors and data are random
      begin
         int acc_n = 0, take_p = 0, rsp_p = 0;
         bit dp_act = 0, dp_err = 0, acc, t_ns;
         int dp_idx = 0, dp_wait = 0, err_stage = 0;
         logic [7:0] dp_data = '0;
         for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge hclk);
            if (dp_act && err_stage == 1) begin hready = 1; hresp = 1; end
            else if (dp_act && dp_wait > 0) begin hready = 0; hresp = 0; end
            else if (dp_act && dp_err) begin hready = 0; hresp = 1; end
            else begin hready = 1; hresp = 0; end
            hrdata = dp_act ? dp_data : 8'($urandom);
            set_cmd(cyc < 660 && acc_n < 500 && ($urandom % 3) != 0, 1'($urandom), 3'($urandom),
                    3'($urandom % 3), 8'($urandom));
            #1;
            if (!hready || hresp) chk("rnd_ready_gate", cmd_ready, 0);
            t_ns = (htrans == 2'b10);
            if (t_ns) begin
               if (take_p >= acc_n) chk("rnd_phantom_nonseq", take_p, acc_n + 1);
               else chk("rnd_addr_phase", {haddr, hwrite, hsize}, {ca[take_p], cw[take_p], cs[take_p]});
            end
            if (dp_act && cw[dp_idx]) chk("rnd_hwdata", hwdata, cd[dp_idx]);
            if (rsp_valid) begin
               if (rsp_p >= acc_n || !res_ok[rsp_p]) chk("rnd_rsp_unexpected", rsp_p, acc_n + 1000);
               else chk("rnd_rsp", {rsp_err, rsp_rdata}, {res_err[rsp_p], res_d[rsp_p]});
               rsp_p++;
            end
            acc = cmd_valid & cmd_ready;
            @(posedge hclk);
            if (acc) begin
               cw[acc_n] = cmd_write; ca[acc_n] = cmd_addr; cs[acc_n] = cmd_size; cd[acc_n] = cmd_wdata;
               res_ok[acc_n] = 0;
               acc_n++;
            end
            if (dp_act) begin
               if (err_stage == 1) begin resolve(dp_idx, 1, 8'h00); dp_act = 0; err_stage = 0; end
               else if (dp_wait > 0) dp_wait--;
               else if (dp_err) begin
                  err_stage = 1;
                  if (t_ns) begin resolve(take_p, 1, 8'h00); take_p++; end
               end else begin
                  resolve(dp_idx, 0, cw[dp_idx] ? 8'h00 : dp_data);
                  dp_act = 0;
               end
            end
            if (hready && t_ns && !dp_act) begin
               dp_act = 1; dp_idx = take_p; take_p++;
               dp_wait = ($urandom % 2) ? 0 : int'($urandom % 4);
               dp_err = ($urandom % 8) == 0;
               dp_data = 8'($urandom);
               err_stage = 0;
            end
         end
         @(negedge hclk);
         #1;
         chk("rnd_all_responded", rsp_p, acc_n);
         chk("rnd_end_busy", busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
